// File: rtl/eeprom_settings_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eeprom_settings_ctrl_pkg
//  Description : Shared constants and state encoding for the EEPROM settings
//                sequencer (transceiver opcodes, EWEN address, FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package eeprom_settings_ctrl_pkg;

    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_EWEN   = 2'b00;

    // EWEN carries its sub-command in the address field
    localparam logic [5:0] EWEN_ADDR = 6'b110000;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_EWEN_ISSUE = 3'd1,
        ST_RD_ISSUE   = 3'd2,
        ST_WR_ISSUE   = 3'd3,
        ST_WAIT_START = 3'd4,
        ST_WAIT_END   = 3'd5,
        ST_DONE       = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/eeprom_settings_ctrl_shadow_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : eeprom_shadow_regfile
//  Description : NWORDS x 16 shadow storage. Host write port with range check,
//                controller write port (has priority), registered host read
//                port and combinational controller read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module eeprom_shadow_regfile #(
    parameter int NWORDS = 8,
    parameter int AW     = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [15:0]   host_wdata_i,
    output logic [15:0]   host_rdata_o,
    input  logic          ctrl_we_i,
    input  logic [AW-1:0] ctrl_idx_i,
    input  logic [15:0]   ctrl_wdata_i,
    output logic [15:0]   ctrl_rdata_o
);

    logic [15:0] mem_q [NWORDS];
    logic [15:0] rdata_q;
    logic        host_in_range;

    // Addresses past the last word read as zero and drop writes
    assign host_in_range = (32'(host_addr_i) < 32'(NWORDS));

    // Storage and registered host read; controller write wins on collision
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (ctrl_we_i) begin
                mem_q[ctrl_idx_i] <= ctrl_wdata_i;
            end else if (host_we_i && host_in_range) begin
                mem_q[host_addr_i] <= host_wdata_i;
            end
            rdata_q <= host_in_range ? mem_q[host_addr_i] : 16'h0000;
        end
    end

    assign host_rdata_o = rdata_q;
    assign ctrl_rdata_o = mem_q[ctrl_idx_i];

endmodule
`default_nettype wire

// File: rtl/eeprom_settings_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : eeprom_settings_ctrl
//  Description : Load/save sequencer between the register bus and an AT93C46
//                transceiver. Restores or saves a shadow file of NWORDS
//                16-bit words, one transaction at a time, with a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module eeprom_settings_ctrl
    import eeprom_settings_ctrl_pkg::*;
#(
    parameter int NWORDS         = 8,
    parameter int BASE_ADDR      = 0,
    parameter int AUTOLOAD       = 1,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int AW             = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic          Load,
    input  logic          Save,
    input  logic [AW-1:0] RegAddr,
    input  logic [15:0]   RegWrData,
    input  logic          RegWe,
    output logic [15:0]   RegRdData,
    output logic          Active,
    output logic          Done,
    output logic          Error,
    output logic          Valid,
    output logic          Dirty,
    output logic          TxSend,
    output logic [1:0]    TxOpcode,
    output logic [5:0]    TxAddress,
    output logic [15:0]   TxData,
    input  logic [15:0]   TxQ,
    input  logic          TxBusy
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NWORDS - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    state_e         state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [5:0]     addr_q, addr_d;
    logic [15:0]    data_q, data_d;
    logic           save_seq_q, save_seq_d;
    logic           auto_q, auto_d;
    logic           error_q, error_d;
    logic           valid_q, valid_d;
    logic           dirty_q, dirty_d;

    logic           shadow_we;
    logic [15:0]    shadow_rd;
    logic           host_we;
    logic           host_in_range;
    logic           issue;

    assign host_we       = RegWe && (state_q == ST_IDLE);
    assign host_in_range = (32'(RegAddr) < 32'(NWORDS));

    eeprom_shadow_regfile #(
        .NWORDS (NWORDS),
        .AW     (AW)
    ) u_regfile (
        .clk_i        (Clock),
        .rst_ni       (Reset_n),
        .host_we_i    (host_we),
        .host_addr_i  (RegAddr),
        .host_wdata_i (RegWrData),
        .host_rdata_o (RegRdData),
        .ctrl_we_i    (shadow_we),
        .ctrl_idx_i   (idx_q),
        .ctrl_wdata_i (TxQ),
        .ctrl_rdata_o (shadow_rd)
    );

    // State and sequencing registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            save_seq_q <= 1'b0;
            auto_q     <= (AUTOLOAD != 0);
            error_q    <= 1'b0;
            valid_q    <= 1'b0;
            dirty_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            save_seq_q <= save_seq_d;
            auto_q     <= auto_d;
            error_q    <= error_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
        end
    end

    // Next-state logic: command decode, transaction issue, wait and timeout
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        save_seq_d = save_seq_q;
        auto_d     = auto_q;
        error_d    = error_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        shadow_we  = 1'b0;

        if (host_we && host_in_range) begin
            dirty_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                auto_d = 1'b0;
                // Load beats Save when both arrive together
                if (Load || auto_q) begin
                    idx_d      = '0;
                    error_d    = 1'b0;
                    save_seq_d = 1'b0;
                    state_d    = ST_RD_ISSUE;
                end else if (Save) begin
                    idx_d      = '0;
                    error_d    = 1'b0;
                    save_seq_d = 1'b1;
                    state_d    = ST_EWEN_ISSUE;
                end
            end
            ST_EWEN_ISSUE: begin
                op_d    = OP_EWEN;
                addr_d  = EWEN_ADDR;
                data_d  = '0;
                cnt_d   = '0;
                state_d = ST_WAIT_START;
            end
            ST_RD_ISSUE: begin
                op_d    = OP_READ;
                addr_d  = 6'(BASE_ADDR) + 6'(idx_q);
                data_d  = '0;
                cnt_d   = '0;
                state_d = ST_WAIT_START;
            end
            ST_WR_ISSUE: begin
                op_d    = OP_WRITE;
                addr_d  = 6'(BASE_ADDR) + 6'(idx_q);
                data_d  = shadow_rd;
                cnt_d   = '0;
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == TO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else if (TxBusy) begin
                    state_d = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == TO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else if (!TxBusy) begin
                    shadow_we = (op_q == OP_READ);
                    if (op_q == OP_EWEN) begin
                        idx_d   = '0;
                        state_d = ST_WR_ISSUE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = (op_q == OP_READ) ? ST_RD_ISSUE : ST_WR_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                if (!error_q) begin
                    dirty_d = 1'b0;
                    if (!save_seq_q) begin
                        valid_d = 1'b1;
                    end
                end else if (!save_seq_q) begin
                    valid_d = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign issue = (state_q == ST_EWEN_ISSUE) || (state_q == ST_RD_ISSUE) ||
                   (state_q == ST_WR_ISSUE);

    // Transaction fields show their new value during ISSUE and hold afterwards
    assign TxSend    = issue;
    assign TxOpcode  = op_d;
    assign TxAddress = addr_d;
    assign TxData    = data_d;

    assign Active = (state_q != ST_IDLE);
    assign Done   = (state_q == ST_DONE);
    assign Error  = error_q;
    assign Valid  = valid_q;
    assign Dirty  = dirty_q;

endmodule
`default_nettype wire

// File: tb/tb_eeprom_settings_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eeprom_settings_ctrl
//  Description : Directed bench for eeprom_settings_ctrl with a small
//                transceiver model (40 busy cycles, TxQ = A000 + address).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eeprom_settings_ctrl;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Load = 1'b0;
    logic        Save = 1'b0;
    logic [2:0]  RegAddr = '0;
    logic [15:0] RegWrData = '0;
    logic        RegWe = 1'b0;
    logic [15:0] RegRdData;
    logic        Active, Done, Error, Valid, Dirty, TxSend;
    logic [1:0]  TxOpcode;
    logic [5:0]  TxAddress;
    logic [15:0] TxData;
    logic [15:0] TxQ = '0;
    logic        TxBusy = 1'b0;

    int checks = 0;
    int failures = 0;

    // transceiver model state and transaction log
    logic        hang = 1'b0;
    int          busy_cnt = 0;
    int          log_n = 0;
    logic [1:0]  log_op   [128];
    logic [5:0]  log_addr [128];
    logic [15:0] log_data [128];
    int          done_cnt = 0;

    eeprom_settings_ctrl #(
        .NWORDS         (8),
        .BASE_ADDR      (0),
        .AUTOLOAD       (1),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Load      (Load),
        .Save      (Save),
        .RegAddr   (RegAddr),
        .RegWrData (RegWrData),
        .RegWe     (RegWe),
        .RegRdData (RegRdData),
        .Active    (Active),
        .Done      (Done),
        .Error     (Error),
        .Valid     (Valid),
        .Dirty     (Dirty),
        .TxSend    (TxSend),
        .TxOpcode  (TxOpcode),
        .TxAddress (TxAddress),
        .TxData    (TxData),
        .TxQ       (TxQ),
        .TxBusy    (TxBusy)
    );

    always #5 Clock = ~Clock;

    // Transceiver: busy from the cycle after TxSend for 40 cycles, logs each send
    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            TxBusy   <= 1'b0;
            busy_cnt <= 0;
        end else if (TxSend) begin
            TxBusy             <= 1'b1;
            busy_cnt           <= 40;
            TxQ                <= 16'hA000 + {10'd0, TxAddress};
            log_op[log_n]      <= TxOpcode;
            log_addr[log_n]    <= TxAddress;
            log_data[log_n]    <= TxData;
            log_n              <= log_n + 1;
        end else if (TxBusy && !hang) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) TxBusy <= 1'b0;
        end
    end

    always @(posedge Clock) begin
        if (Done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge Clock);
            if (Done === 1'b1) begin
                cyc = i + 1;
                break;
            end
        end
    endtask

    task automatic read_reg(input int idx, output logic [15:0] v);
        RegAddr = 3'(idx);
        @(negedge Clock);
        v = RegRdData;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge Clock);
    endtask

    initial begin
        int          base;
        int          cyc;
        int          dc0;
        logic [15:0] v;
        logic        found;

        // ---------------- reset state ----------------
        idle(3);
        check("rst_active", {31'd0, Active}, 0);
        check("rst_done",   {31'd0, Done}, 0);
        check("rst_flags",  {29'd0, Error, Valid, Dirty}, 0);
        check("rst_txsend", {31'd0, TxSend}, 0);
        check("rst_txfields", {8'd0, TxOpcode, TxAddress, TxData}, 0);
        check("rst_rdata",  {16'd0, RegRdData}, 0);

        // ---------------- autoload ----------------
        base = log_n;
        dc0  = done_cnt;
        Reset_n = 1'b1;
        wait_done(2000, cyc);
        check("auto_done_seen", {31'd0, cyc > 0}, 1);
        idle(5);
        check("auto_done_pulses", done_cnt - dc0, 1);
        check("auto_count", log_n - base, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("auto_op%0d", i), {30'd0, log_op[base+i]}, 32'h2);
            check($sformatf("auto_addr%0d", i), {26'd0, log_addr[base+i]}, i);
        end
        for (int i = 0; i < 8; i++) begin
            read_reg(i, v);
            check($sformatf("auto_shadow%0d", i), {16'd0, v}, 32'hA000 + i);
        end
        check("auto_valid", {31'd0, Valid}, 1);
        check("auto_dirty", {31'd0, Dirty}, 0);
        check("auto_error", {31'd0, Error}, 0);

        // ---------------- host write then save ----------------
        RegAddr = 3'd3; RegWrData = 16'h1234; RegWe = 1'b1;
        @(negedge Clock);
        RegWe = 1'b0;
        check("wr_dirty", {31'd0, Dirty}, 1);
        @(negedge Clock);
        check("wr_readback", {16'd0, RegRdData}, 32'h1234);
        base = log_n;
        Save = 1'b1;
        @(negedge Clock);
        Save = 1'b0;
        wait_done(2000, cyc);
        check("save_done_seen", {31'd0, cyc > 0}, 1);
        check("save_count", log_n - base, 9);
        check("save_ewen_op",   {30'd0, log_op[base]}, 0);
        check("save_ewen_addr", {26'd0, log_addr[base]}, 32'h30);
        check("save_ewen_data", {16'd0, log_data[base]}, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("save_op%0d", i), {30'd0, log_op[base+1+i]}, 32'h1);
            check($sformatf("save_addr%0d", i), {26'd0, log_addr[base+1+i]}, i);
            check($sformatf("save_data%0d", i), {16'd0, log_data[base+1+i]},
                  (i == 3) ? 32'h1234 : 32'hA000 + i);
        end
        @(negedge Clock);
        check("save_dirty", {31'd0, Dirty}, 0);
        check("save_valid", {31'd0, Valid}, 1);

        // ---------------- Load and Save together ----------------
        base = log_n;
        Load = 1'b1; Save = 1'b1;
        @(negedge Clock);
        Load = 1'b0; Save = 1'b0;
        wait_done(2000, cyc);
        check("both_done_seen", {31'd0, cyc > 0}, 1);
        idle(50);
        check("both_idle", {31'd0, Active}, 0);
        check("both_count", log_n - base, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("both_op%0d", i), {30'd0, log_op[base+i]}, 32'h2);
        end
        read_reg(3, v);
        check("both_shadow3", {16'd0, v}, 32'hA003);

        // ---------------- host traffic during a load ----------------
        base = log_n;
        Load = 1'b1;
        @(negedge Clock);
        Load = 1'b0;
        idle(10);
        RegAddr = 3'd2; RegWrData = 16'hBEEF; RegWe = 1'b1;
        @(negedge Clock);
        RegWe = 1'b0;
        Save = 1'b1;
        @(negedge Clock);
        Save = 1'b0;
        wait_done(2000, cyc);
        check("busy_done_seen", {31'd0, cyc > 0}, 1);
        idle(50);
        check("busy_idle", {31'd0, Active}, 0);
        check("busy_count", log_n - base, 8);
        check("busy_dirty", {31'd0, Dirty}, 0);
        read_reg(2, v);
        check("busy_shadow2", {16'd0, v}, 32'hA002);

        // ---------------- timeout ----------------
        hang = 1'b1;
        base = log_n;
        Load = 1'b1;
        @(negedge Clock);
        Load = 1'b0;
        check("to_txsend", {31'd0, TxSend}, 1);
        wait_done(400, cyc);
        check("to_latency", cyc, 101);
        check("to_error", {31'd0, Error}, 1);
        @(negedge Clock);
        check("to_valid", {31'd0, Valid}, 0);
        check("to_count", log_n - base, 1);
        hang = 1'b0;
        idle(60);
        Load = 1'b1;
        @(negedge Clock);
        Load = 1'b0;
        check("to_error_cleared", {31'd0, Error}, 0);
        wait_done(2000, cyc);
        check("to_reload_done", {31'd0, cyc > 0}, 1);
        @(negedge Clock);
        check("to_reload_valid", {31'd0, Valid}, 1);

        // ---------------- reset during 4th WRITE ----------------
        Save = 1'b1;
        @(negedge Clock);
        Save = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (TxSend && TxOpcode == 2'b01 && TxAddress == 6'd3) begin
                found = 1'b1;
                break;
            end
            @(negedge Clock);
        end
        check("mid_found_write4", {31'd0, found}, 1);
        Reset_n = 1'b0;
        #1;
        check("mid_txsend", {31'd0, TxSend}, 0);
        check("mid_active", {31'd0, Active}, 0);
        check("mid_flags", {28'd0, Done, Error, Valid, Dirty}, 0);
        check("mid_txfields", {8'd0, TxOpcode, TxAddress, TxData}, 0);
        check("mid_rdata", {16'd0, RegRdData}, 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (TxSend) begin
                found = 1'b1;
                break;
            end
        end
        check("rel_autoload_send", {31'd0, found}, 1);
        check("rel_op", {30'd0, TxOpcode}, 32'h2);
        check("rel_addr", {26'd0, TxAddress}, 0);
        wait_done(2000, cyc);
        check("rel_done_seen", {31'd0, cyc > 0}, 1);
        @(negedge Clock);
        check("rel_valid", {31'd0, Valid}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
